// File: rtl/npu_inst_decoder_pkg.sv
// NPU instruction decoder shared types: opcode/unit encodings, instruction layout, FSM states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package npu_inst_decoder_pkg;

   // Instruction word bit positions
   localparam int OP_MSB   = 63;
   localparam int OP_LSB   = 56;
   localparam int DST_MSB  = 55;
   localparam int DST_LSB  = 40;
   localparam int SRC_MSB  = 39;
   localparam int SRC_LSB  = 24;
   localparam int LEN_MSB  = 23;
   localparam int LEN_LSB  = 8;
   localparam int FLG_MSB  = 7;
   localparam int FLG_LSB  = 0;

   typedef enum logic [7:0] {
      OP_NOP   = 8'h00,
      OP_LOAD  = 8'h01,
      OP_STORE = 8'h02,
      OP_CONV  = 8'h10,
      OP_GEMM  = 8'h11,
      OP_ACT   = 8'h20,
      OP_POOL  = 8'h30,
      OP_SYNC  = 8'hF0,
      OP_HALT  = 8'hFF
   } opcode_e;

   typedef enum logic [1:0] {
      UNIT_DMA  = 2'd0,
      UNIT_PE   = 2'd1,
      UNIT_ACT  = 2'd2,
      UNIT_POOL = 2'd3
   } unit_e;

   // Opcode kept as raw bits: illegal values must be representable.
   typedef struct packed {
      logic [7:0]  opcode;
      logic [15:0] dst;
      logic [15:0] src;
      logic [15:0] len;
      logic [7:0]  flags;
   } inst_t;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FETCH,
      ST_ISSUE,
      ST_WAIT_SYNC,
      ST_DONE,
      ST_ERROR
   } dec_state_e;

endpackage

// File: rtl/npu_inst_decoder_if.sv
// Decoder bus bundle: upstream instruction buffer read side plus the command channel to dispatch.
// Latency: n/a (wiring only).
// Backpressure: cmd_valid/cmd_ready on the command side; buf_empty/buf_rd_en on the buffer side.
// Ports: buf_empty, buf_rd_data, buf_rd_en, buf_flush, cmd_valid, cmd_ready, cmd_unit/op/dst/src/len/flags.
interface npu_inst_decoder_if #(
   parameter int INST_WIDTH = 64
);
   logic                  buf_empty;
   logic [INST_WIDTH-1:0] buf_rd_data;
   logic                  buf_rd_en;
   logic                  buf_flush;

   logic                  cmd_valid;
   logic                  cmd_ready;
   logic [1:0]            cmd_unit;
   logic [7:0]            cmd_op;
   logic [15:0]           cmd_dst;
   logic [15:0]           cmd_src;
   logic [15:0]           cmd_len;
   logic [7:0]            cmd_flags;

   // master = decoder side, slave = buffer/dispatch side
   modport master (
      input  buf_empty, buf_rd_data, cmd_ready,
      output buf_rd_en, buf_flush, cmd_valid, cmd_unit, cmd_op,
             cmd_dst, cmd_src, cmd_len, cmd_flags
   );

   modport slave (
      output buf_empty, buf_rd_data, cmd_ready,
      input  buf_rd_en, buf_flush, cmd_valid, cmd_unit, cmd_op,
             cmd_dst, cmd_src, cmd_len, cmd_flags
   );
endinterface

// File: rtl/npu_inst_field_decode.sv
// Opcode classifier: maps an instruction to its target unit and flags control/illegal opcodes.
// Latency: combinational.
// Backpressure: none.
// Ports: inst (in), unit / is_ctrl / is_illegal (out).
module npu_inst_field_decode
   import npu_inst_decoder_pkg::*;
(
   input  inst_t inst,
   output unit_e unit,
   output logic  is_ctrl,
   output logic  is_illegal
);

   always_comb begin
      unit       = UNIT_DMA;
      is_ctrl    = 1'b0;
      is_illegal = 1'b0;
      case (inst.opcode)
         OP_LOAD, OP_STORE:       unit = UNIT_DMA;
         OP_CONV, OP_GEMM:        unit = UNIT_PE;
         OP_ACT:                  unit = UNIT_ACT;
         OP_POOL:                 unit = UNIT_POOL;
         OP_NOP, OP_SYNC, OP_HALT: is_ctrl = 1'b1;
         default:                 is_illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/npu_inst_decoder.sv
// NPU instruction decoder: pops 64-bit instructions, issues unit commands, executes NOP/SYNC/HALT.
// Latency: one cycle from buffer consume to cmd_valid; one instruction per cycle when cmd_ready stays high.
// Backpressure: cmd_ready low holds cmd_* stable and stops buffer reads; SYNC stalls until units idle.
// Ports: clk, rst, start, abort, units_busy, busy, done, error, inst_count, bus (master modport).
module npu_inst_decoder
   import npu_inst_decoder_pkg::*;
#(
   parameter int INST_WIDTH = 64,
   parameter int NUM_UNITS  = 4,
   parameter int CNT_WIDTH  = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic                 abort,
   input  logic [NUM_UNITS-1:0] units_busy,
   output logic                 busy,
   output logic                 done,
   output logic                 error,
   output logic [CNT_WIDTH-1:0] inst_count,
   npu_inst_decoder_if.master   bus
);

   dec_state_e state_q, state_d, branch_st;

   inst_t      inst;
   unit_e      dec_unit;
   logic       is_ctrl, is_illegal;

   logic       rd_en, hs, start_ok, idle_like;
   logic       sync_hold_q, flush_q, done_q, error_q, cnt_pend_q;
   logic [1:0] cnt_events;
   logic [CNT_WIDTH-1:0] cnt_q;

   logic [1:0]  cmd_unit_q;
   logic [7:0]  cmd_op_q, cmd_flags_q;
   logic [15:0] cmd_dst_q, cmd_src_q, cmd_len_q;

   assign inst = bus.buf_rd_data[INST_WIDTH-1:0];

   npu_inst_field_decode u_field_decode (
      .inst       (inst),
      .unit       (dec_unit),
      .is_ctrl    (is_ctrl),
      .is_illegal (is_illegal)
   );

   assign idle_like = (state_q == ST_IDLE) || (state_q == ST_DONE) || (state_q == ST_ERROR);
   assign start_ok  = start && !abort && idle_like;
   assign hs        = (state_q == ST_ISSUE) && bus.cmd_ready;
   assign rd_en     = ((state_q == ST_FETCH) || hs) && !bus.buf_empty && !abort;

   // Where a consumed entry sends the FSM (shared by FETCH and the ISSUE handshake).
   always_comb begin
      branch_st = ST_FETCH;
      if (is_illegal) begin
         branch_st = ST_ERROR;
      end else if (!is_ctrl) begin
         branch_st = ST_ISSUE;
      end else if (inst.opcode == OP_SYNC) begin
         branch_st = ST_WAIT_SYNC;
      end else if (inst.opcode == OP_HALT) begin
         branch_st = ST_DONE;
      end
   end

   always_comb begin
      state_d = state_q;
      if (abort) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE, ST_DONE, ST_ERROR: begin
               if (start) state_d = ST_FETCH;
            end
            ST_FETCH: begin
               if (rd_en) state_d = branch_st;
            end
            ST_ISSUE: begin
               if (bus.cmd_ready) state_d = rd_en ? branch_st : ST_FETCH;
            end
            ST_WAIT_SYNC: begin
               // sync_hold_q covers a command handed off last cycle whose unit
               // has not yet raised its busy flag.
               if ((units_busy == '0) && !sync_hold_q) state_d = ST_FETCH;
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   // A handshake and a consumed control opcode can land in the same cycle,
   // but the counter only steps by one per cycle; the second retirement is
   // parked in cnt_pend_q and applied on the next cycle (always free, since
   // the FSM leaves ISSUE when it consumes a control opcode).
   assign cnt_events = {1'b0, hs} + {1'b0, rd_en && is_ctrl} + {1'b0, cnt_pend_q};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         sync_hold_q <= 1'b0;
         flush_q     <= 1'b0;
         done_q      <= 1'b0;
         error_q     <= 1'b0;
         cnt_pend_q  <= 1'b0;
         cnt_q       <= '0;
         cmd_unit_q  <= '0;
         cmd_op_q    <= '0;
         cmd_dst_q   <= '0;
         cmd_src_q   <= '0;
         cmd_len_q   <= '0;
         cmd_flags_q <= '0;
      end else begin
         state_q     <= state_d;
         sync_hold_q <= hs;
         flush_q     <= abort;
         done_q      <= rd_en && is_ctrl && (inst.opcode == OP_HALT);

         if (rd_en) begin
            cmd_unit_q  <= dec_unit;
            cmd_op_q    <= inst.opcode;
            cmd_dst_q   <= inst.dst;
            cmd_src_q   <= inst.src;
            cmd_len_q   <= inst.len;
            cmd_flags_q <= inst.flags;
         end

         if (start_ok && (state_q == ST_ERROR)) begin
            error_q <= 1'b0;
         end else if (rd_en && is_illegal) begin
            error_q <= 1'b1;
         end

         if (start_ok) begin
            cnt_q      <= '0;
            cnt_pend_q <= 1'b0;
         end else begin
            if (cnt_events != 2'd0) cnt_q <= cnt_q + 1'b1;
            cnt_pend_q <= cnt_events[1];
         end
      end
   end

   assign busy       = (state_q == ST_FETCH) || (state_q == ST_ISSUE) || (state_q == ST_WAIT_SYNC);
   assign done       = done_q;
   assign error      = error_q;
   assign inst_count = cnt_q;

   assign bus.buf_rd_en = rd_en;
   assign bus.buf_flush = flush_q;
   assign bus.cmd_valid = (state_q == ST_ISSUE);
   assign bus.cmd_unit  = cmd_unit_q;
   assign bus.cmd_op    = cmd_op_q;
   assign bus.cmd_dst   = cmd_dst_q;
   assign bus.cmd_src   = cmd_src_q;
   assign bus.cmd_len   = cmd_len_q;
   assign bus.cmd_flags = cmd_flags_q;

endmodule

// File: tb/tb_npu_inst_decoder.sv
// Testbench for npu_inst_decoder: opcode table, directed multi-cycle sequences, random programs vs. a list-level model.
// Latency: n/a.
// Backpressure: drives random cmd_ready, buffer gaps and units_busy.
module tb_npu_inst_decoder;
   import npu_inst_decoder_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic        abort = 1'b0;
   logic [3:0]  units_busy = 4'd0;
   logic        busy, done, error;
   logic [31:0] inst_count;

   npu_inst_decoder_if #(.INST_WIDTH(64)) bus ();

   npu_inst_decoder #(.INST_WIDTH(64), .NUM_UNITS(4), .CNT_WIDTH(32)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .abort      (abort),
      .units_busy (units_busy),
      .busy       (busy),
      .done       (done),
      .error      (error),
      .inst_count (inst_count),
      .bus        (bus.master)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- upstream buffer model (show-ahead) ----------------
   logic [63:0] mem [256];
   int          wr_ptr = 0;
   int          rd_ptr = 0;
   logic        gap = 1'b0;

   assign bus.buf_empty   = gap || (rd_ptr == wr_ptr);
   assign bus.buf_rd_data = mem[rd_ptr[7:0]];

   always @(posedge clk) begin
      if (rst || bus.buf_flush) rd_ptr <= wr_ptr;
      else if (bus.buf_rd_en)   rd_ptr <= rd_ptr + 1;
   end

   task automatic push(input logic [63:0] w);
      mem[wr_ptr[7:0]] = w;
      wr_ptr++;
   endtask

   function automatic logic [63:0] mk(input logic [7:0] op, input logic [15:0] d,
                                      input logic [15:0] s, input logic [15:0] l,
                                      input logic [7:0] f);
      return {op, d, s, l, f};
   endfunction

   // ---------------- output monitor ----------------
   typedef struct packed {
      logic [1:0]  unit;
      logic [7:0]  op;
      logic [15:0] dst;
      logic [15:0] src;
      logic [15:0] len;
      logic [7:0]  flags;
   } cmd_t;

   cmd_t        issued_q[$];
   cmd_t        cur, stall_cmd;
   logic        stalled = 1'b0;
   logic [31:0] prev_cnt = 32'd0;
   int          cyc = 0, hs_cnt = 0, valid_cycles = 0, done_cnt = 0, flush_cnt = 0;
   int          last_hs_cyc = 0, prev_hs_cyc = 0;

   always @(negedge clk) begin
      cyc++;
      if (rst) begin
         stalled  = 1'b0;
         prev_cnt = 32'd0;
      end else begin
         cur = '{bus.cmd_unit, bus.cmd_op, bus.cmd_dst, bus.cmd_src, bus.cmd_len, bus.cmd_flags};
         if (stalled) begin
            check("hold_valid", 64'(bus.cmd_valid), 64'd1);
            check("hold_fields", 64'(cur == stall_cmd), 64'd1);
         end
         if (bus.cmd_valid) valid_cycles++;
         if (bus.cmd_valid && bus.cmd_ready) begin
            issued_q.push_back(cur);
            hs_cnt++;
            prev_hs_cyc = last_hs_cyc;
            last_hs_cyc = cyc;
         end
         stalled   = bus.cmd_valid && !bus.cmd_ready && !abort;
         stall_cmd = cur;
         if (done) done_cnt++;
         if (bus.buf_flush) flush_cnt++;
         if (inst_count != prev_cnt)
            check("count_step", 64'((inst_count == prev_cnt + 32'd1) || (inst_count == 32'd0)), 64'd1);
         prev_cnt = inst_count;
      end
   end

   // ---------------- reference model: walk the program as a list ----------------
   logic [63:0] prog_q[$];
   cmd_t        exp_q[$];
   int          exp_cnt;
   bit          exp_err;

   function automatic logic [1:0] unit_of(input logic [7:0] op);
      case (op)
         8'h01, 8'h02: return 2'd0;
         8'h10, 8'h11: return 2'd1;
         8'h20:        return 2'd2;
         default:      return 2'd3;
      endcase
   endfunction

   task automatic model();
      logic [63:0] w;
      exp_q.delete();
      exp_cnt = 0;
      exp_err = 0;
      foreach (prog_q[i]) begin
         w = prog_q[i];
         if (w[63:56] inside {8'h01, 8'h02, 8'h10, 8'h11, 8'h20, 8'h30}) begin
            exp_q.push_back('{unit_of(w[63:56]), w[63:56], w[55:40], w[39:24], w[23:8], w[7:0]});
            exp_cnt++;
         end else if (w[63:56] inside {8'h00, 8'hF0}) begin
            exp_cnt++;
         end else if (w[63:56] == 8'hFF) begin
            exp_cnt++;
            break;
         end else begin
            exp_err = 1;
            break;
         end
      end
   endtask

   // ---------------- helpers ----------------
   task automatic tick(input int n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      bus.cmd_ready = 1'b0;
      gap = 1'b0;
      units_busy = 4'd0;
      tick(2);
      rst = 1'b0;
      tick();
      issued_q.delete();
      hs_cnt = 0; valid_cycles = 0; done_cnt = 0; flush_cnt = 0;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic wait_idle(input string name, input int budget);
      int k;
      for (k = 0; k < budget && busy; k++) tick();
      if (busy) check({name, "_timeout"}, 64'd1, 64'd0);
   endtask

   task automatic wait_valid(input string name, input int budget);
      int k;
      for (k = 0; k < budget && !bus.cmd_valid; k++) tick();
      if (!bus.cmd_valid) check({name, "_timeout"}, 64'd1, 64'd0);
   endtask

   typedef struct {
      logic [7:0] op;
      bit         issues;
      logic [1:0] unit;
      bit         err;
      int         cnt;
   } vec_t;

   vec_t vt[10];

   initial begin
      logic [63:0] w;
      logic [7:0]  ops[8];

      vt[0] = '{8'h01, 1, 2'd0, 0, 2};
      vt[1] = '{8'h02, 1, 2'd0, 0, 2};
      vt[2] = '{8'h10, 1, 2'd1, 0, 2};
      vt[3] = '{8'h11, 1, 2'd1, 0, 2};
      vt[4] = '{8'h20, 1, 2'd2, 0, 2};
      vt[5] = '{8'h30, 1, 2'd3, 0, 2};
      vt[6] = '{8'h00, 0, 2'd0, 0, 2};
      vt[7] = '{8'hF0, 0, 2'd0, 0, 2};
      vt[8] = '{8'hFF, 0, 2'd0, 0, 1};
      vt[9] = '{8'h42, 0, 2'd0, 1, 0};
      ops = '{8'h01, 8'h02, 8'h10, 8'h11, 8'h20, 8'h30, 8'h00, 8'hF0};

      foreach (mem[i]) mem[i] = 64'd0;
      bus.cmd_ready = 1'b0;

      // Reset state
      do_reset();
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_done", 64'(done), 64'd0);
      check("rst_error", 64'(error), 64'd0);
      check("rst_count", 64'(inst_count), 64'd0);
      check("rst_valid", 64'(bus.cmd_valid), 64'd0);
      check("rst_rd_en", 64'(bus.buf_rd_en), 64'd0);
      check("rst_flush", 64'(bus.buf_flush), 64'd0);
      check("rst_fields", 64'({bus.cmd_unit, bus.cmd_op, bus.cmd_dst, bus.cmd_flags}), 64'd0);

      // Opcode table: one instruction followed by HALT
      foreach (vt[i]) begin
         do_reset();
         bus.cmd_ready = 1'b1;
         w = mk(vt[i].op, 16'($urandom), 16'($urandom), 16'($urandom), 8'($urandom));
         push(w);
         push(mk(8'hFF, 16'd0, 16'd0, 16'd0, 8'd0));
         pulse_start();
         wait_idle("tbl_run", 40);
         tick(2);
         check($sformatf("tbl_hs_%0h", vt[i].op), 64'(hs_cnt), 64'(vt[i].issues));
         if (vt[i].issues && issued_q.size() > 0) begin
            check($sformatf("tbl_unit_%0h", vt[i].op), 64'(issued_q[0].unit), 64'(vt[i].unit));
            check($sformatf("tbl_dst_%0h", vt[i].op), 64'(issued_q[0].dst), 64'(w[55:40]));
         end
         check($sformatf("tbl_err_%0h", vt[i].op), 64'(error), 64'(vt[i].err));
         check($sformatf("tbl_cnt_%0h", vt[i].op), 64'(inst_count), 64'(vt[i].cnt));
         check($sformatf("tbl_done_%0h", vt[i].op), 64'(done_cnt), 64'(vt[i].err ? 0 : 1));
      end

      // Seq 1: LOAD, CONV, HALT back to back
      do_reset();
      bus.cmd_ready = 1'b1;
      push(mk(8'h01, 16'h0100, 16'h0200, 16'd64, 8'h00));
      push(mk(8'h10, 16'h0300, 16'h0400, 16'd9, 8'h05));
      push(mk(8'hFF, 16'd0, 16'd0, 16'd0, 8'd0));
      pulse_start();
      wait_idle("s1_run", 20);
      tick(2);
      check("s1_hs", 64'(hs_cnt), 64'd2);
      check("s1_b2b", 64'(last_hs_cyc - prev_hs_cyc), 64'd1);
      if (issued_q.size() == 2) begin
         check("s1_unit0", 64'(issued_q[0].unit), 64'd0);
         check("s1_fields0", {issued_q[0].dst, issued_q[0].src, issued_q[0].len, 16'd0},
               {16'h0100, 16'h0200, 16'd64, 16'd0});
         check("s1_unit1", 64'(issued_q[1].unit), 64'd1);
      end
      check("s1_done", 64'(done_cnt), 64'd1);
      check("s1_count", 64'(inst_count), 64'd3);

      // Seq 2: CONV stalled 5 cycles
      do_reset();
      push(mk(8'h10, 16'hAAAA, 16'h5555, 16'd17, 8'h3C));
      push(mk(8'hFF, 16'd0, 16'd0, 16'd0, 8'd0));
      pulse_start();
      wait_valid("s2_valid", 10);
      for (int k = 0; k < 5; k++) begin
         check("s2_valid_held", 64'(bus.cmd_valid), 64'd1);
         check("s2_fields", {bus.cmd_op, bus.cmd_dst, bus.cmd_src, bus.cmd_flags, 8'd0},
               {8'h10, 16'hAAAA, 16'h5555, 8'h3C, 8'd0});
         check("s2_no_rd", 64'(bus.buf_rd_en), 64'd0);
         tick();
      end
      bus.cmd_ready = 1'b1;
      #1;
      check("s2_rd_on_hs", 64'(bus.buf_rd_en), 64'd1);
      tick();
      check("s2_issued", 64'(hs_cnt), 64'd1);
      check("s2_done", 64'(done), 64'd1);

      // Seq 3: GEMM, SYNC, ACT with a busy unit
      do_reset();
      bus.cmd_ready = 1'b1;
      push(mk(8'h11, 16'd1, 16'd2, 16'd3, 8'd4));
      push(mk(8'hF0, 16'd0, 16'd0, 16'd0, 8'd0));
      push(mk(8'h20, 16'd7, 16'd8, 16'd9, 8'd1));
      push(mk(8'hFF, 16'd0, 16'd0, 16'd0, 8'd0));
      pulse_start();
      wait_valid("s3_gemm", 10);
      tick();
      units_busy = 4'b0010;
      for (int k = 0; k < 10; k++) begin
         check("s3_stalled", 64'(bus.cmd_valid), 64'd0);
         tick();
      end
      check("s3_hs_before", 64'(hs_cnt), 64'd1);
      units_busy = 4'b0000;
      wait_valid("s3_act", 10);
      check("s3_act_unit", 64'(bus.cmd_unit), 64'd2);
      check("s3_act_op", 64'(bus.cmd_op), 64'h20);
      wait_idle("s3_run", 20);
      tick(2);
      check("s3_count", 64'(inst_count), 64'd4);

      // Seq 4: illegal opcode, then restart
      do_reset();
      bus.cmd_ready = 1'b1;
      push(mk(8'h00, 16'd0, 16'd0, 16'd0, 8'd0));
      push(mk(8'h7E, 16'd0, 16'd0, 16'd0, 8'd0));
      push(mk(8'h01, 16'h1234, 16'd0, 16'd0, 8'd0));
      push(mk(8'hFF, 16'd0, 16'd0, 16'd0, 8'd0));
      pulse_start();
      wait_idle("s4_run", 20);
      tick(2);
      check("s4_error", 64'(error), 64'd1);
      check("s4_no_valid", 64'(valid_cycles), 64'd0);
      check("s4_count", 64'(inst_count), 64'd1);
      pulse_start();
      check("s4_err_clr", 64'(error), 64'd0);
      check("s4_cnt_clr", 64'(inst_count), 64'd0);
      wait_idle("s4_rerun", 20);
      check("s4_load", 64'(hs_cnt), 64'd1);

      // Seq 5: abort while stalled in ISSUE
      do_reset();
      push(mk(8'h01, 16'd5, 16'd6, 16'd7, 8'd8));
      push(mk(8'hFF, 16'd0, 16'd0, 16'd0, 8'd0));
      pulse_start();
      wait_valid("s5_valid", 10);
      abort = 1'b1;
      #1;
      check("s5_no_rd", 64'(bus.buf_rd_en), 64'd0);
      tick();
      abort = 1'b0;
      check("s5_valid_drop", 64'(bus.cmd_valid), 64'd0);
      check("s5_busy", 64'(busy), 64'd0);
      check("s5_flush", 64'(bus.buf_flush), 64'd1);
      check("s5_error", 64'(error), 64'd0);
      tick();
      check("s5_flush_pulse", 64'(flush_cnt), 64'd1);
      check("s5_flushed", 64'(bus.buf_empty), 64'd1);

      // Seq 6: NOPs and HALT trickling in
      do_reset();
      bus.cmd_ready = 1'b1;
      pulse_start();
      for (int k = 0; k < 4; k++) begin
         tick(3);
         check("s6_waiting", 64'(busy), 64'd1);
         push(mk(k == 3 ? 8'hFF : 8'h00, 16'd0, 16'd0, 16'd0, 8'd0));
      end
      wait_idle("s6_run", 20);
      tick(2);
      check("s6_no_valid", 64'(valid_cycles), 64'd0);
      check("s6_count", 64'(inst_count), 64'd4);
      check("s6_done", 64'(done_cnt), 64'd1);

      // Random programs vs. model, restarted from DONE each time
      do_reset();
      for (int it = 0; it < 20; it++) begin
         prog_q.delete();
         for (int k = 0; k < int'($urandom_range(4, 14)); k++)
            prog_q.push_back(mk(ops[$urandom_range(0, 7)], 16'($urandom), 16'($urandom),
                                16'($urandom), 8'($urandom)));
         prog_q.push_back(mk(8'hFF, 16'($urandom), 16'd0, 16'd0, 8'd0));
         model();
         foreach (prog_q[i]) push(prog_q[i]);
         issued_q.delete();
         hs_cnt = 0; done_cnt = 0;
         pulse_start();
         for (int k = 0; k < 2000 && busy; k++) begin
            bus.cmd_ready = ($urandom_range(0, 9) < 7);
            gap           = ($urandom_range(0, 3) == 0);
            units_busy    = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'd0;
            tick();
         end
         if (busy) check("rnd_timeout", 64'd1, 64'd0);
         bus.cmd_ready = 1'b0; gap = 1'b0; units_busy = 4'd0;
         tick(2);
         check("rnd_issued_n", 64'(issued_q.size()), 64'(exp_q.size()));
         foreach (exp_q[i])
            if (i < issued_q.size())
               check($sformatf("rnd_cmd_%0d", i), 64'(issued_q[i] == exp_q[i]), 64'd1);
         check("rnd_count", 64'(inst_count), 64'(exp_cnt));
         check("rnd_done", 64'(done_cnt), 64'd1);
         check("rnd_error", 64'(error), 64'(exp_err));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
